// File: rtl/ttt_move_selector_if.sv
// Board-button / move bus between the tic-tac-toe input stage and its environment.
// Stimulus side: btn_next, btn_confirm (raw buttons), game_active, winner, occupied.
// Move side: player1/player2 turn selects, player1_pos/player2_pos committed cells,
// assign_pulse move strobe, cursor highlight and timeout_flag auto-move marker.
interface ttt_move_selector_if;
  logic       btn_next;
  logic       btn_confirm;
  logic       game_active;
  logic [1:0] winner;
  logic [8:0] occupied;
  logic       player1;
  logic       player2;
  logic [3:0] player1_pos;
  logic [3:0] player2_pos;
  logic       assign_pulse;
  logic [3:0] cursor;
  logic       timeout_flag;

  modport master (
    output btn_next, btn_confirm, game_active, winner, occupied,
    input  player1, player2, player1_pos, player2_pos, assign_pulse, cursor, timeout_flag
  );

  modport slave (
    input  btn_next, btn_confirm, game_active, winner, occupied,
    output player1, player2, player1_pos, player2_pos, assign_pulse, cursor, timeout_flag
  );
endinterface

// File: rtl/ttt_move_selector.sv
// Tic-tac-toe move selector: debounces the next/confirm buttons and turns them into
// alternating player moves, rejecting occupied cells and auto-playing the lowest free
// cell when a turn times out.
// Ports: clock, reset (synchronous, active-high), bus (slave side of ttt_move_selector_if).
module ttt_move_selector #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 100
) (
  input  logic                 clock,
  input  logic                 reset,
  ttt_move_selector_if.slave   bus
);

  localparam int unsigned CELLS = 9;
  localparam int unsigned POS_W = 4;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TM_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned NEXT    = 0;
  localparam int unsigned CONFIRM = 1;
  localparam logic [POS_W-1:0] LAST_CELL = POS_W'(CELLS - 1);
  localparam logic [CELLS-1:0] ALL_TAKEN = '1;

  typedef enum logic [2:0] {
    IDLE, P1_SEL, P1_COMMIT, P2_SEL, P2_COMMIT, DONE
  } state_t;

  state_t            state;
  logic [1:0]        sync1;
  logic [1:0]        sync2;
  logic [1:0]        level;
  logic [1:0]        press;
  logic [DB_W-1:0]   db_cnt [2];
  logic [TM_W-1:0]   timer;
  logic [POS_W-1:0]  free_cell;
  logic              p1_sel;
  logic              p2_sel;
  logic [POS_W-1:0]  p1_pos;
  logic [POS_W-1:0]  p2_pos;
  logic              pulse;
  logic              auto_move;
  logic [POS_W-1:0]  cursor_reg;

  // Synchronize and debounce both buttons; press is a one-cycle rising-edge event.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      level  <= '0;
      press  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {bus.btn_confirm, bus.btn_next};
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Lowest-index free cell, used for the timeout auto-move.
  always_comb begin
    free_cell = '0;
    for (int i = CELLS - 1; i >= 0; i--) begin
      if (!bus.occupied[i]) free_cell = POS_W'(i);
    end
  end

  // Turn sequencing with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      p1_sel     <= 1'b0;
      p2_sel     <= 1'b0;
      p1_pos     <= '0;
      p2_pos     <= '0;
      pulse      <= 1'b0;
      auto_move  <= 1'b0;
      cursor_reg <= '0;
    end else begin
      pulse     <= 1'b0;
      auto_move <= 1'b0;
      if (!bus.game_active) begin
        state      <= IDLE;
        timer      <= '0;
        p1_sel     <= 1'b0;
        p2_sel     <= 1'b0;
        p1_pos     <= '0;
        p2_pos     <= '0;
        cursor_reg <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.winner != 2'b00) begin
              state <= DONE;
            end else begin
              state      <= P1_SEL;
              p1_sel     <= 1'b1;
              p2_sel     <= 1'b0;
              cursor_reg <= '0;
              timer      <= '0;
            end
          end
          P1_SEL, P2_SEL: begin
            if (bus.winner != 2'b00 || bus.occupied == ALL_TAKEN) begin
              state  <= DONE;
              p1_sel <= 1'b0;
              p2_sel <= 1'b0;
            end else if (press[CONFIRM] && !bus.occupied[cursor_reg]) begin
              state <= (state == P1_SEL) ? P1_COMMIT : P2_COMMIT;
              pulse <= 1'b1;
              if (state == P1_SEL) p1_pos <= cursor_reg;
              else                 p2_pos <= cursor_reg;
            end else if (timer == TM_W'(TIMEOUT_CYCLES - 1)) begin
              state     <= (state == P1_SEL) ? P1_COMMIT : P2_COMMIT;
              pulse     <= 1'b1;
              auto_move <= 1'b1;
              if (state == P1_SEL) p1_pos <= free_cell;
              else                 p2_pos <= free_cell;
            end else if (!press[CONFIRM]) begin
              // A rejected confirm freezes the turn for that cycle, next included.
              timer <= timer + TM_W'(1);
              if (press[NEXT]) begin
                cursor_reg <= (cursor_reg == LAST_CELL) ? '0 : cursor_reg + POS_W'(1);
              end
            end
          end
          P1_COMMIT, P2_COMMIT: begin
            if (bus.winner != 2'b00) begin
              state  <= DONE;
              p1_sel <= 1'b0;
              p2_sel <= 1'b0;
            end else begin
              state      <= (state == P1_COMMIT) ? P2_SEL : P1_SEL;
              p1_sel     <= (state == P2_COMMIT);
              p2_sel     <= (state == P1_COMMIT);
              cursor_reg <= '0;
              timer      <= '0;
            end
          end
          DONE: begin
            p1_sel <= 1'b0;
            p2_sel <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.player1      = p1_sel;
  assign bus.player2      = p2_sel;
  assign bus.player1_pos  = p1_pos;
  assign bus.player2_pos  = p2_pos;
  assign bus.assign_pulse = pulse;
  assign bus.cursor       = cursor_reg;
  assign bus.timeout_flag = auto_move;

endmodule

// File: tb/tb_ttt_move_selector.sv
// Self-checking bench for ttt_move_selector: directed turn sequence, with every
// move strobe checked against a queue of expected moves.
module tb_ttt_move_selector;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ttt_move_selector_if bus();

  ttt_move_selector #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0] sel;   // {player2, player1}
    logic [3:0] pos;
    logic       tf;
  } move_t;

  move_t      sb[$];
  move_t      got;
  int         n_cmp = 0;
  int         n_err = 0;
  int         pulse_count = 0;
  logic [3:0] pulse_cursor = '0;
  logic       prev_pulse = 1'b0;
  int         k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Clean press: 5 cycles high, 4 low, so the debounced level has fallen before the next press.
  task automatic press(input logic nxt, input logic cnf);
    bus.btn_next    = nxt;
    bus.btn_confirm = cnf;
    tick(5);
    bus.btn_next    = 1'b0;
    bus.btn_confirm = 1'b0;
    tick(4);
  endtask

  task automatic expect_move(input logic [1:0] sel, input logic [3:0] pos, input logic tf);
    move_t m;
    m.sel = sel;
    m.pos = pos;
    m.tf  = tf;
    sb.push_back(m);
  endtask

  task automatic wait_pulse(input int max, output int cycles);
    cycles = 0;
    for (int i = 1; i <= max; i++) begin
      tick(1);
      if (bus.assign_pulse === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Move monitor: every strobe must match the next expected move.
  always @(negedge clock) begin
    if (reset !== 1'b0) begin
      prev_pulse = 1'b0;
    end else begin
      if (bus.timeout_flag === 1'b1 && bus.assign_pulse !== 1'b1)
        chk("timeout_flag_without_pulse", 32'(bus.timeout_flag), 32'd0);
      if (bus.assign_pulse === 1'b1) begin
        pulse_count++;
        pulse_cursor = bus.cursor;
        chk("pulse_single_cycle", 32'(prev_pulse), 32'd0);
        chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          chk("pulse_player", 32'({bus.player2, bus.player1}), 32'(got.sel));
          chk("pulse_pos", 32'((got.sel == 2'b01) ? bus.player1_pos : bus.player2_pos), 32'(got.pos));
          chk("pulse_timeout_flag", 32'(bus.timeout_flag), 32'(got.tf));
        end
      end
      prev_pulse = bus.assign_pulse;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.btn_next    = 1'b0;
    bus.btn_confirm = 1'b0;
    bus.game_active = 1'b1;
    bus.winner      = 2'b00;
    bus.occupied    = 9'h000;

    // Reset: everything idle.
    repeat (3) begin
      tick(1);
      chk("reset_outputs", 32'({bus.player1, bus.player2, bus.player1_pos, bus.player2_pos,
                                bus.assign_pulse, bus.cursor, bus.timeout_flag}), 32'd0);
    end
    reset = 1'b0;
    tick(1);
    chk("p1_after_reset", 32'({bus.player2, bus.player1}), 32'h1);
    chk("cursor_after_reset", 32'(bus.cursor), 32'd0);

    // Player 1: four nexts then confirm on cell 4.
    repeat (4) press(1'b1, 1'b0);
    chk("p1_cursor_after_4_next", 32'(bus.cursor), 32'd4);
    expect_move(2'b01, 4'd4, 1'b0);
    press(1'b0, 1'b1);
    chk("p1_commit_count", 32'(pulse_count), 32'd1);
    chk("p1_commit_cursor", 32'(pulse_cursor), 32'd4);
    chk("p1_pos_held", 32'(bus.player1_pos), 32'd4);
    chk("p2_turn", 32'({bus.player2, bus.player1}), 32'h2);
    chk("p2_cursor_start", 32'(bus.cursor), 32'd0);

    // Player 2: cursor to 8 and wrap, rejected confirm on occupied cell 0.
    repeat (8) press(1'b1, 1'b0);
    chk("p2_cursor_at_8", 32'(bus.cursor), 32'd8);
    press(1'b1, 1'b0);
    chk("p2_cursor_wrap", 32'(bus.cursor), 32'd0);
    bus.occupied = 9'h001;
    press(1'b0, 1'b1);
    chk("occupied_confirm_no_pulse", 32'(pulse_count), 32'd1);
    chk("occupied_confirm_still_p2", 32'({bus.player2, bus.player1}), 32'h2);
    chk("occupied_confirm_cursor", 32'(bus.cursor), 32'd0);
    // Turn budget is nearly spent; the auto-move takes lowest free cell 1.
    expect_move(2'b10, 4'd1, 1'b1);
    wait_pulse(40, k);
    chk("p2_first_timeout_seen", 32'(k != 0), 32'd1);
    chk("p1_pos_kept_in_p2_turn", 32'(bus.player1_pos), 32'd4);
    tick(1);

    // Player 1: glitch is filtered, then next + simultaneous next/confirm.
    bus.occupied = 9'h000;
    chk("p1_second_turn", 32'({bus.player2, bus.player1}), 32'h1);
    bus.btn_confirm = 1'b1;
    tick(2);
    bus.btn_confirm = 1'b0;
    tick(8);
    chk("glitch_no_pulse", 32'(pulse_count), 32'd2);
    chk("glitch_still_p1", 32'({bus.player2, bus.player1}), 32'h1);
    press(1'b1, 1'b0);
    chk("p1_cursor_1", 32'(bus.cursor), 32'd1);
    expect_move(2'b01, 4'd1, 1'b0);
    press(1'b1, 1'b1);
    chk("simul_commit_count", 32'(pulse_count), 32'd3);
    chk("simul_cursor_not_advanced", 32'(pulse_cursor), 32'd1);
    chk("p2_pos_kept_in_p1_turn", 32'(bus.player2_pos), 32'd1);

    // Player 2 idles a full turn: P2_SEL was entered one cycle before this point,
    // so the 100th turn cycle ends with the strobe 99 ticks from now.
    bus.occupied = 9'h013;
    expect_move(2'b10, 4'd2, 1'b1);
    wait_pulse(120, k);
    chk("p2_idle_timeout_cycle", 32'(k), 32'd99);
    chk("p2_timeout_pos", 32'(bus.player2_pos), 32'd2);
    chk("p2_timeout_flag", 32'(bus.timeout_flag), 32'd1);
    tick(1);

    // Winner during P1_SEL: game over, no more moves.
    tick(3);
    chk("p1_third_turn", 32'({bus.player2, bus.player1}), 32'h1);
    bus.winner = 2'b01;
    tick(1);
    chk("done_selects_low", 32'({bus.player2, bus.player1}), 32'h0);
    press(1'b0, 1'b1);
    tick(120);
    chk("done_no_pulses", 32'(pulse_count), 32'd4);
    chk("done_selects_stay_low", 32'({bus.player2, bus.player1}), 32'h0);

    // New game.
    bus.game_active = 1'b0;
    bus.winner      = 2'b00;
    bus.occupied    = 9'h000;
    tick(1);
    chk("idle_positions_cleared", 32'({bus.player1_pos, bus.player2_pos}), 32'd0);
    chk("idle_selects_low", 32'({bus.player2, bus.player1}), 32'h0);
    bus.game_active = 1'b1;
    tick(1);
    chk("new_game_p1", 32'({bus.player2, bus.player1}), 32'h1);
    chk("new_game_cursor", 32'(bus.cursor), 32'd0);

    // Reset mid-turn aborts it without a strobe.
    press(1'b1, 1'b0);
    chk("new_game_cursor_1", 32'(bus.cursor), 32'd1);
    reset = 1'b1;
    tick(1);
    chk("midgame_reset_outputs", 32'({bus.player1, bus.player2, bus.cursor, bus.assign_pulse}), 32'd0);
    reset = 1'b0;
    tick(1);
    chk("after_midgame_reset_p1", 32'({bus.player2, bus.player1}), 32'h1);
    chk("after_midgame_reset_cursor", 32'(bus.cursor), 32'd0);
    tick(2);
    chk("total_pulses", 32'(pulse_count), 32'd4);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
